// File: rtl/hc_gate_bank_if.sv
// Handshake bundle for hc_gate_bank: function select, operands, input/output valid-ready.
interface hc_gate_bank_if #(
  parameter int WIDTH = 4
);
  logic [2:0]       OP;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] Y;
  logic             OUT_VALID;
  logic             OUT_READY;

  modport master (
    output OP, A, B, IN_VALID, OUT_READY,
    input  IN_READY, Y, OUT_VALID
  );

  modport slave (
    input  OP, A, B, IN_VALID, OUT_READY,
    output IN_READY, Y, OUT_VALID
  );
endinterface

// File: rtl/hc_gate_bank.sv
// Registered, flow-controlled WIDTH-bit bitwise gate bank with a STAGES-deep skid-free pipeline.
// Optional output-transfer counter XFER_CNT enabled by macro HC_GATE_BANK_STATS_EN.
module hc_gate_bank #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 1
) (
  input  logic                CLK,
  input  logic                RST,
  hc_gate_bank_if.slave       bus
`ifdef HC_GATE_BANK_STATS_EN
  ,
  output logic [15:0]         XFER_CNT
`endif
);

  if (WIDTH < 1 || WIDTH > 64 || STAGES < 1 || STAGES > 4) begin : g_param_check
    $fatal(1, "hc_gate_bank: illegal parameters WIDTH=%0d STAGES=%0d", WIDTH, STAGES);
  end

  function automatic logic [WIDTH-1:0] gate_fn(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] res;
    case (op)
      3'b000:  res = ~(a & b);
      3'b001:  res = ~(a | b);
      3'b010:  res = ~a;
      3'b011:  res = a & b;
      3'b100:  res = a | b;
      3'b101:  res = a ^ b;
      3'b110:  res = ~(a ^ b);
      default: res = a;
    endcase
    return res;
  endfunction

  logic [STAGES:1]  r_vld;
  logic [WIDTH-1:0] r_dat [1:STAGES];
  logic [STAGES:1]  w_rdy;
  logic [WIDTH-1:0] w_fn;

  assign w_fn = gate_fn(bus.OP, bus.A, bus.B);

  // A stage can load if the consumer takes the tail or any stage at or after it is empty.
  for (genvar i = 1; i <= STAGES; i++) begin : g_rdy
    assign w_rdy[i] = bus.OUT_READY | ~(&r_vld[STAGES:i]);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_vld <= '0;
      for (int i = 1; i <= STAGES; i++) r_dat[i] <= '0;
    end else begin
      if (w_rdy[1]) begin
        r_vld[1] <= bus.IN_VALID;
        r_dat[1] <= w_fn;
      end
      for (int i = 2; i <= STAGES; i++) begin
        if (w_rdy[i]) begin
          r_vld[i] <= r_vld[i-1];
          r_dat[i] <= r_dat[i-1];
        end
      end
    end
  end

  assign bus.IN_READY  = w_rdy[1];
  assign bus.Y         = r_dat[STAGES];
  assign bus.OUT_VALID = r_vld[STAGES];

`ifdef HC_GATE_BANK_STATS_EN
  logic [15:0] r_xfer_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_xfer_cnt <= '0;
    end else if (bus.OUT_VALID && bus.OUT_READY && r_xfer_cnt != 16'hFFFF) begin
      r_xfer_cnt <= r_xfer_cnt + 16'd1;
    end
  end

  assign XFER_CNT = r_xfer_cnt;
`endif

endmodule

// File: tb/tb_hc_gate_bank.sv
// Directed bench for hc_gate_bank: three instances (W4/S1, W6/S3, W4/S2) sharing clock and reset.
module tb_hc_gate_bank;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hc_gate_bank_if #(.WIDTH(4)) b1 ();
  hc_gate_bank_if #(.WIDTH(6)) b3 ();
  hc_gate_bank_if #(.WIDTH(4)) b2 ();

`ifdef HC_GATE_BANK_STATS_EN
  logic [15:0] cnt1, cnt3, cnt2;
`endif

  hc_gate_bank #(.WIDTH(4), .STAGES(1)) dut1 (
    .CLK(clk), .RST(rst), .bus(b1)
`ifdef HC_GATE_BANK_STATS_EN
    , .XFER_CNT(cnt1)
`endif
  );

  hc_gate_bank #(.WIDTH(6), .STAGES(3)) dut3 (
    .CLK(clk), .RST(rst), .bus(b3)
`ifdef HC_GATE_BANK_STATS_EN
    , .XFER_CNT(cnt3)
`endif
  );

  hc_gate_bank #(.WIDTH(4), .STAGES(2)) dut2 (
    .CLK(clk), .RST(rst), .bus(b2)
`ifdef HC_GATE_BANK_STATS_EN
    , .XFER_CNT(cnt2)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] sweep_exp [0:7];

  initial begin
    sweep_exp = '{4'b0111, 4'b0001, 4'b0011, 4'b1000, 4'b1110, 4'b0110, 4'b1001, 4'b1100};

    rst = 1'b1;
    b1.OP = 3'b000; b1.A = '0; b1.B = '0; b1.IN_VALID = 1'b0; b1.OUT_READY = 1'b1;
    b3.OP = 3'b000; b3.A = '0; b3.B = '0; b3.IN_VALID = 1'b0; b3.OUT_READY = 1'b1;
    b2.OP = 3'b000; b2.A = '0; b2.B = '0; b2.IN_VALID = 1'b0; b2.OUT_READY = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_y1", 64'(b1.Y), 64'h0);
    chk("rst_ov1", 64'(b1.OUT_VALID), 64'h0);
    chk("rst_ir1", 64'(b1.IN_READY), 64'h1);
    chk("rst_ov3", 64'(b3.OUT_VALID), 64'h0);
    chk("rst_ov2", 64'(b2.OUT_VALID), 64'h0);
`ifdef HC_GATE_BANK_STATS_EN
    chk("rst_cnt1", 64'(cnt1), 64'h0);
`endif

    // Function sweep, single stage
    b1.A = 4'b1100; b1.B = 4'b1010;
    for (int k = 0; k < 8; k++) begin
      b1.OP = 3'(k);
      b1.IN_VALID = 1'b1;
      step();
      chk($sformatf("sweep_y_op%0d", k), 64'(b1.Y), 64'(sweep_exp[k]));
      chk($sformatf("sweep_ov_op%0d", k), 64'(b1.OUT_VALID), 64'h1);
`ifdef HC_GATE_BANK_STATS_EN
      if (k == 5) chk("cnt_after5", 64'(cnt1), 64'd5);
`endif
    end
    b1.IN_VALID = 1'b0;
    step();
    chk("sweep_bubble_ov", 64'(b1.OUT_VALID), 64'h0);

`ifdef HC_GATE_BANK_STATS_EN
    chk("cnt_after8", 64'(cnt1), 64'd8);
    force dut1.r_xfer_cnt = 16'hFFFD;
    #1;
    release dut1.r_xfer_cnt;
    b1.OP = 3'b111; b1.A = 4'h5; b1.IN_VALID = 1'b1;
    step();
    step();
    step();
    b1.IN_VALID = 1'b0;
    step();
    step();
    chk("cnt_saturate", 64'(cnt1), 64'hFFFF);
`endif

    // Latency and throughput, three stages, XOR against all-ones
    b3.OP = 3'b101; b3.B = 6'h3F;
    for (int c = 0; c < 14; c++) begin
      b3.IN_VALID = (c < 10);
      b3.A = 6'(c);
      step();
      if (c < 10) chk($sformatf("lat_ir_c%0d", c), 64'(b3.IN_READY), 64'h1);
      if (c >= 2 && c < 12) begin
        chk($sformatf("lat_ov_c%0d", c), 64'(b3.OUT_VALID), 64'h1);
        chk($sformatf("lat_y_c%0d", c), 64'(b3.Y), 64'((~6'(c - 2)) & 6'h3F));
      end else begin
        chk($sformatf("lat_noval_c%0d", c), 64'(b3.OUT_VALID), 64'h0);
      end
    end

    // Backpressure, two stages, pass-through
    b2.OP = 3'b111; b2.B = 4'hF; b2.OUT_READY = 1'b0;
    b2.A = 4'h1; b2.IN_VALID = 1'b1;
    step();
    chk("bp_ir_1", 64'(b2.IN_READY), 64'h1);
    chk("bp_ov_1", 64'(b2.OUT_VALID), 64'h0);
    b2.A = 4'h2;
    step();
    chk("bp_ir_full", 64'(b2.IN_READY), 64'h0);
    chk("bp_ov_full", 64'(b2.OUT_VALID), 64'h1);
    chk("bp_y_full", 64'(b2.Y), 64'h1);
    b2.A = 4'h3;
    step();
    chk("bp_ir_hold", 64'(b2.IN_READY), 64'h0);
    chk("bp_y_hold", 64'(b2.Y), 64'h1);
    step();
    chk("bp_y_hold2", 64'(b2.Y), 64'h1);
    chk("bp_ov_hold2", 64'(b2.OUT_VALID), 64'h1);
    b2.OUT_READY = 1'b1;
    #1;
    chk("bp_ir_release", 64'(b2.IN_READY), 64'h1);
    step();
    chk("bp_y_2", 64'(b2.Y), 64'h2);
    chk("bp_ov_2", 64'(b2.OUT_VALID), 64'h1);
    b2.A = 4'h4;
    step();
    chk("bp_y_3", 64'(b2.Y), 64'h3);
    b2.IN_VALID = 1'b0;
    step();
    chk("bp_y_4", 64'(b2.Y), 64'h4);
    chk("bp_ov_4", 64'(b2.OUT_VALID), 64'h1);
    step();
    chk("bp_drained", 64'(b2.OUT_VALID), 64'h0);

    // Reset mid-stream, three stages
    b3.OP = 3'b101; b3.B = 6'h3F;
    b3.A = 6'h05; b3.IN_VALID = 1'b1;
    step();
    b3.A = 6'h06;
    step();
    b3.A = 6'h07;
    rst = 1'b1;
    step();
    rst = 1'b0;
    b3.IN_VALID = 1'b0;
    chk("mid_rst_ir", 64'(b3.IN_READY), 64'h1);
`ifdef HC_GATE_BANK_STATS_EN
    chk("mid_rst_cnt1", 64'(cnt1), 64'h0);
`endif
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("mid_rst_ov_c%0d", c), 64'(b3.OUT_VALID), 64'h0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
